// File: rtl/breakout_sched_pkg.sv
// Shared types and field widths for the sprite draw scheduler.
package breakout_sched_pkg;

  localparam int unsigned X_W   = 8;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned COL_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    GRANT_FIRST,
    GRANT,
    RELEASE,
    ROUND_END
  } sched_state_e;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
    logic             plot;
  } pixel_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of pending at or above rr_ptr, with wrap.
module rr_pick #(
  parameter int unsigned N_REQ = 3,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;
  logic [SUM_W-1:0] sum;

  always_comb begin
    rot = N_REQ'({pending, pending} >> rr_ptr);
    off = '0;
    // Descending scan so the smallest offset from rr_ptr wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
    idx = sum[IDX_W-1:0];
    any = |pending;
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Round-based arbiter sharing the VGA adapter write port among sprite controllers.
// Optional per-grant watchdog compiled in with SCHED_WATCHDOG_EN.
module sprite_draw_scheduler
  import breakout_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                   clock,
  input  logic                   reset_state,
  input  logic                   frame_tick,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ-1:0]       done,
  input  logic [X_W*N_REQ-1:0]   x_in,
  input  logic [Y_W*N_REQ-1:0]   y_in,
  input  logic [COL_W*N_REQ-1:0] colour_in,
  input  logic [N_REQ-1:0]       plot_in,
  output logic [N_REQ-1:0]       enable_state,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [COL_W-1:0]       vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   round_done,
  output logic                   overrun,
  output logic [N_REQ-1:0]       fault
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (TIMEOUT == 0 || N_REQ == 0) begin : g_param_chk
    $error("sprite_draw_scheduler: TIMEOUT and N_REQ must be nonzero");
  end

  sched_state_e     state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             overrun_q, overrun_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  pixel_t           pix_c;

`ifdef SCHED_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] fault_q, fault_d;
  assign fault = fault_q;
`else
  assign fault = '0;
`endif

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .pending (pending_q),
    .rr_ptr  (rr_ptr_q),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  // Granted requester's pixel fields.
  always_comb begin
    pix_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx_q == IDX_W'(i)) begin
        pix_c.x      = x_in[i*X_W +: X_W];
        pix_c.y      = y_in[i*Y_W +: Y_W];
        pix_c.colour = colour_in[i*COL_W +: COL_W];
        pix_c.plot   = plot_in[i];
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_idx_d    = gnt_idx_q;
    overrun_d    = overrun_q | (frame_tick & (state_q != IDLE));
    enable_state = '0;
    vga_x        = '0;
    vga_y        = '0;
    vga_colour   = '0;
    vga_plot     = 1'b0;
    round_done   = 1'b0;
`ifdef SCHED_WATCHDOG_EN
    cnt_d        = cnt_q;
    fault_d      = fault_q;
`endif
    if (state_q == GRANT_FIRST || state_q == GRANT) begin
      vga_x      = pix_c.x;
      vga_y      = pix_c.y;
      vga_colour = pix_c.colour;
      vga_plot   = pix_c.plot;
`ifdef SCHED_WATCHDOG_EN
      cnt_d      = cnt_q + CNT_W'(1);
`endif
    end
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          pending_d = req;
          state_d   = ARB;
        end
      end
      ARB: begin
        if (!pick_any) begin
          state_d = ROUND_END;
        end else begin
          gnt_idx_d = pick_idx;
          state_d   = GRANT_FIRST;
`ifdef SCHED_WATCHDOG_EN
          cnt_d     = '0;
`endif
        end
      end
      GRANT_FIRST: begin
        // Requester is still in its previous hold state, so done is not consulted.
        enable_state[gnt_idx_q] = 1'b1;
        state_d                 = GRANT;
      end
      GRANT: begin
        enable_state[gnt_idx_q] = ~done[gnt_idx_q];
        if (done[gnt_idx_q]) begin
          pending_d[gnt_idx_q] = 1'b0;
          state_d              = RELEASE;
        end
`ifdef SCHED_WATCHDOG_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          fault_d[gnt_idx_q]   = 1'b1;
          pending_d[gnt_idx_q] = 1'b0;
          state_d              = RELEASE;
        end
`endif
      end
      RELEASE: state_d = ARB;
      ROUND_END: begin
        round_done = 1'b1;
        rr_ptr_d   = (rr_ptr_q == IDX_W'(N_REQ - 1)) ? '0 : rr_ptr_q + IDX_W'(1);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_state) begin
    if (!reset_state) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      overrun_q <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      cnt_q     <= '0;
      fault_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      overrun_q <= overrun_d;
`ifdef SCHED_WATCHDOG_EN
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Self-checking bench for sprite_draw_scheduler: directed round table, reset cases, random rounds.
module tb_sprite_draw_scheduler;

  localparam int unsigned N = 3;
`ifdef SCHED_WATCHDOG_EN
  localparam int unsigned TO = 8;
  localparam bit WD = 1'b1;
`else
  localparam int unsigned TO = 1023;
  localparam bit WD = 1'b0;
`endif

  logic clock;
  logic reset_state;
  logic frame_tick;
  logic [N-1:0] req, done, plot_in, enable_state, fault;
  logic [8*N-1:0] x_in;
  logic [7*N-1:0] y_in;
  logic [3*N-1:0] colour_in;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic vga_plot, busy, round_done, overrun;

  sprite_draw_scheduler #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clock(clock), .reset_state(reset_state), .frame_tick(frame_tick),
    .req(req), .done(done), .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
    .plot_in(plot_in), .enable_state(enable_state), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
    .round_done(round_done), .overrun(overrun), .fault(fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  // Reference state kept at round granularity.
  int       rr_m;
  bit       ovr_m;
  logic [2:0] fault_m;
  logic [2:0] done_r;
  int       cnt [3];

  typedef struct {
    logic [2:0]  req;
    int          d0;
    int          d1;
    int          d2;
    bit          noise;
    bit          x157;
    logic [15:0] order;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // One round: tick, then per-cycle comparison against a timeline built from the round rules.
  task automatic run_round(input logic [2:0] r, input int d0, input int d1, input int d2,
                           input bit noise_fixed, input bit noise_rnd, input bit x157,
                           output logic [15:0] obs, output logic [15:0] mdl);
    logic [2:0] e_en [128];
    int         e_g  [128];
    logic [2:0] fset [128];
    int         dd [3];
    int         t, re, g, oc, mc;
    logic [11:0] ov, mv;
    logic [2:0] prev_en;
    logic [18:0] exp_vga;
    dd = '{d0, d1, d2};
    for (int c = 0; c < 128; c++) begin
      e_en[c] = '0; e_g[c] = -1; fset[c] = '0;
    end
    t = 2; mc = 0; mv = '0;
    for (int k = 0; k < 3; k++) begin
      g = (rr_m + k) % 3;
      if (r[g]) begin
        mv = {mv[7:0], 4'(g)}; mc++;
        if (WD && dd[g] >= int'(TO)) begin
          for (int c = t; c < t + int'(TO); c++) begin e_en[c] = 3'(1 << g); e_g[c] = g; end
          fset[t + int'(TO)] = 3'(1 << g);
          t += int'(TO) + 2;
        end else begin
          for (int c = t; c < t + dd[g]; c++) e_en[c] = 3'(1 << g);
          for (int c = t; c <= t + dd[g]; c++) e_g[c] = g;
          t += dd[g] + 3;
        end
      end
    end
    re = t;
    mdl = {4'(mc), mv};
    oc = 0; ov = '0; prev_en = '0;
    for (int rel = 0; rel <= re + 1; rel++) begin
      @(posedge clock); #1;
      frame_tick = (rel == 0) ||
                   (rel >= 1 && rel <= re &&
                    ((noise_fixed && rel == 3) || (noise_rnd && $urandom_range(0, 9) == 0)));
      req       = (rel == 0) ? r : 3'($urandom);
      done      = done_r;
      x_in      = 24'($urandom);
      y_in      = 21'($urandom);
      colour_in = 9'($urandom);
      plot_in   = 3'($urandom);
      if (x157) x_in[15:8] = 8'd157;
      @(negedge clock);
      g = e_g[rel];
      exp_vga = (g >= 0) ? {8'(x_in >> (8*g)), 7'(y_in >> (7*g)), 3'(colour_in >> (3*g)),
                            1'(plot_in >> g)} : '0;
      fault_m |= fset[rel];
      chk("enable_state", 32'(enable_state), 32'(e_en[rel]));
      chk("vga_port", 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'(exp_vga));
      chk("round_done", 32'(round_done), 32'(rel == re));
      chk("busy", 32'(busy), 32'(rel >= 1 && rel <= re));
      chk("overrun", 32'(overrun), 32'(ovr_m));
      chk("fault", 32'(fault), 32'(fault_m));
      if (frame_tick && rel >= 1) ovr_m = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (enable_state[i] && !prev_en[i]) begin ov = {ov[7:0], 4'(i)}; oc++; end
        // Requester model: leaves hold when enabled, re-enters hold after dd enabled cycles.
        if (enable_state[i]) begin
          cnt[i]++;
          done_r[i] = (cnt[i] >= dd[i]);
        end else begin
          cnt[i] = 0;
        end
      end
      prev_en = enable_state;
    end
    obs = {4'(oc), ov};
    rr_m = (rr_m + 1) % 3;
  endtask

  initial begin
    logic [15:0] obs, mdl;
    tbl[0] = '{3'b111, 4, 4, 4, 1'b0, 1'b0, 16'h3012};
    tbl[1] = '{3'b111, 4, 4, 4, 1'b0, 1'b0, 16'h3120};
    tbl[2] = '{3'b111, 4, 4, 4, 1'b0, 1'b0, 16'h3201};
    tbl[3] = '{3'b100, 4, 4, 4, 1'b0, 1'b0, 16'h1002};
    tbl[4] = '{3'b000, 4, 4, 4, 1'b0, 1'b0, 16'h0000};
    tbl[5] = '{3'b001, 1, 4, 4, 1'b0, 1'b0, 16'h1000};
    tbl[6] = '{3'b111, 3, 5, 2, 1'b1, 1'b1, 16'h3012};
    tbl[7] = '{3'b011, 2, 3, 4, 1'b0, 1'b0, 16'h2010};
    tbl[8] = '{3'b110, 4, 20, 3, 1'b0, 1'b0, 16'h2021};

    rr_m = 0; ovr_m = 1'b0; fault_m = '0; done_r = 3'b111;
    for (int i = 0; i < 3; i++) cnt[i] = 0;
    reset_state = 1'b0; frame_tick = 1'b0; req = '0; done = done_r;
    x_in = '0; y_in = '0; colour_in = '0; plot_in = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_outputs", 32'({enable_state, vga_x, vga_y, vga_colour, vga_plot}), 32'd0);
    chk("rst_flags", 32'({busy, round_done, overrun, fault}), 32'd0);
    reset_state = 1'b1;

    for (int v = 0; v < 9; v++) begin
      run_round(tbl[v].req, tbl[v].d0, tbl[v].d1, tbl[v].d2, tbl[v].noise, 1'b0, tbl[v].x157,
                obs, mdl);
      chk($sformatf("order_tbl%0d", v), 32'(obs), 32'(tbl[v].order));
    end

    // Reset asserted mid-grant abandons the round and clears sticky flags.
    @(posedge clock); #1; frame_tick = 1'b1; req = 3'b001; done = done_r;
    @(posedge clock); #1; frame_tick = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("rst_mid_pre_en", 32'(enable_state), 32'd1);
    #2 reset_state = 1'b0;
    #1;
    chk("rst_mid_en", 32'(enable_state), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ovr", 32'({overrun, fault}), 32'd0);
    @(posedge clock); #1 reset_state = 1'b1;
    @(negedge clock);
    rr_m = 0; ovr_m = 1'b0; fault_m = '0;
    for (int i = 0; i < 3; i++) cnt[i] = 0;

    for (int n = 0; n < 30; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int k = 0; k < gap; k++) begin
        @(posedge clock); #1; frame_tick = 1'b0; req = 3'($urandom);
        @(negedge clock);
        chk("idle_en", 32'({enable_state, busy}), 32'd0);
      end
      run_round(3'($urandom), 1 + $urandom_range(0, 5), 1 + $urandom_range(0, 5),
                1 + $urandom_range(0, 5), 1'b0, 1'b1, 1'b0, obs, mdl);
      chk($sformatf("order_rnd%0d", n), 32'(obs), 32'(mdl));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sprite_draw_scheduler.md
# sprite_draw_scheduler

Round-based scheduler that shares the single VGA adapter write port among the sprite controllers (ball, paddle, brick field). Each `frame_tick` opens a round; every requester that asked to draw gets exactly one exclusive grant, during which its `enable_state` is high and its pixel stream is muxed to the adapter. A grant ends when the requester raises its `done` level, which also freezes the requester's FSM in its hold state. Sits between the sprite controllers and `vga_adapter` in the top level.

## Interface
- `N_REQ`, 3: number of requesters; index 0 = ball, 1 = paddle, 2 = bricks.
- `TIMEOUT`, 1023: watchdog limit in cycles per grant; counter width `$clog2(TIMEOUT+1)`.
- `clock`  in  1  system clock, all state on rising edge.
- `reset_state`  in  1  asynchronous, active-low reset.
- `frame_tick`  in  1  one-cycle pulse that starts a round.
- `req`  in  N_REQ  per-requester draw request, sampled only on an accepted tick.
- `done`  in  N_REQ  per-requester level, high while the requester sits in a hold state.
- `x_in`  in  8*N_REQ  packed pixel x, requester i at bits [8i+7:8i].
- `y_in`  in  7*N_REQ  packed pixel y.
- `colour_in`  in  3*N_REQ  packed colour.
- `plot_in`  in  N_REQ  per-requester plot strobe.
- `enable_state`  out  N_REQ  per-requester FSM advance enable; at most one bit high.
- `vga_x`  out  8, `vga_y`  out  7, `vga_colour`  out  3, `vga_plot`  out  1  muxed adapter port.
- `busy`  out  1  high in every state except IDLE.
- `round_done`  out  1  one-cycle pulse when a round ends.
- `overrun`  out  1  sticky: a tick arrived outside IDLE.
- `fault`  out  N_REQ  sticky per-requester watchdog flags (present only with the watchdog compiled in).

## Operation
- States: IDLE, ARB, GRANT_FIRST, GRANT, RELEASE, ROUND_END.
- IDLE: on `frame_tick`, latch `pending <= req` and go to ARB.
- ARB: if `pending == 0`, go to ROUND_END. Otherwise select the first set bit of `pending`, scanning upward from `rr_ptr` with wrap. Register it as `gnt_idx` and go to GRANT_FIRST.
- GRANT_FIRST, exactly one cycle: `enable_state[gnt_idx] = 1`. `done` is ignored, because the requester is still holding from its previous step. Go to GRANT.
- GRANT: `enable_state[gnt_idx] = ~done[gnt_idx]`. This is combinational, so the requester freezes in the same cycle its `done` rises. When `done[gnt_idx]` is high, clear `pending[gnt_idx]` and go to RELEASE.
- RELEASE, one cycle: all `enable_state` bits low. Go to ARB.
- ROUND_END, one cycle: `round_done = 1`; `rr_ptr <= rr_ptr + 1`, wrapping modulo N_REQ. Go to IDLE.
- Mux: in GRANT_FIRST and GRANT, the `vga_*` outputs equal requester `gnt_idx`'s fields, with `vga_plot = plot_in[gnt_idx]`. In all other states the `vga_*` outputs are 0.
- `frame_tick` in any state other than IDLE (including ROUND_END) is dropped and sets `overrun`. The tick is dropped, not queued.
- `req` changes mid-round have no effect on the current round.

## Timing
- Reset values: state IDLE, `pending` 0, `rr_ptr` 0, `gnt_idx` 0, every output 0 (`overrun` and `fault` cleared).
- Tick accepted at edge T → ARB in cycle T+1 → first `enable_state` high in cycle T+2.
- Grant-to-grant overhead: RELEASE + ARB = 2 idle cycles.
- Empty round: tick → ARB → ROUND_END, so `round_done` is high 2 cycles after the tick.
- Reset asserted mid-grant: `enable_state` drops asynchronously; the round is abandoned.

## Configuration
- `SCHED_WATCHDOG_EN` defined:
  - A counter clears on entry to GRANT_FIRST and increments each grant cycle.
  - Reaching `TIMEOUT` without `done` sets `fault[gnt_idx]`, clears `pending[gnt_idx]` and goes to RELEASE.
- `SCHED_WATCHDOG_EN` undefined: no counter, `fault` is tied 0, and a grant waits indefinitely.

## Structure
- Package `breakout_sched_pkg`: state enum, `X_W=8`, `Y_W=7`, `COL_W=3`.
- Sub-module `rr_pick`: combinational rotating-priority encoder. Inputs `pending`, `rr_ptr`; outputs `idx` and `any`.

## Test plan
- Basic round: `req=3'b111`, `rr_ptr=0`, each requester raises `done` 4 cycles into its grant → grant order 0,1,2; `round_done` pulses once; 2 gap cycles between grants.
- Rotation: second round with `req=3'b111` → order 1,2,0; third round → order 2,0,1.
- Sparse and empty: `req=3'b100` → only requester 2 is granted. `req=0` → `round_done` exactly 2 cycles after the tick, with no `enable_state` activity.
- Held done: `done[0]` already high when granted → `enable_state[0]` is high in GRANT_FIRST, then follows `~done[0]`; the grant ends on the next high `done` seen in GRANT.
- Overrun and mux: tick during a grant → `overrun=1` and the round is unaffected. `x_in` for requester 1 = 8'd157 during its grant → `vga_x=157`, and `vga_plot` follows `plot_in[1]`.
- Watchdog (`SCHED_WATCHDOG_EN`, `TIMEOUT=8`): requester 1 never raises `done` → `fault=3'b010` after 8 grant cycles; requester 2 is still served and `round_done` fires.
